// File: rtl/countdown_pkg.sv
// Shared types and constants for the MM:SS BCD countdown timer.
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX      = 4'd9;
    localparam bcd_t SEC_TENS_MAX = 4'd5;

    function automatic bcd_t clamp_digit(input bcd_t d, input bcd_t lim);
        return (d > lim) ? lim : d;
    endfunction

    // Total remaining seconds of an MM:SS value; 99:59 fits in 13 bits.
    function automatic logic [12:0] total_secs(input logic [15:0] d);
        return (13'(d[15:12]) * 13'd600) + (13'(d[11:8]) * 13'd60)
             + (13'(d[7:4]) * 13'd10) + 13'(d[3:0]);
    endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// One BCD digit of the down-counter: decrement on borrow-in, wrap to wrap_val at zero.
module bcd_digit_dec
    import countdown_pkg::*;
(
    input  bcd_t digit,
    input  logic borrow_in,
    input  bcd_t wrap_val,
    output bcd_t result,
    output logic borrow_out
);

    // Single-digit decrement with borrow propagation
    always_comb begin
        result     = digit;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (digit == 4'd0) begin
                result     = wrap_val;
                borrow_out = 1'b1;
            end else begin
                result     = digit - 4'd1;
                borrow_out = 1'b0;
            end
        end else begin
            result     = digit;
            borrow_out = 1'b0;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer driven by a 1 Hz slow_clk sampled in the CLKin domain.
// Optional warning output is enabled by defining TIMER_WARN_EN.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int WARN_SECS = 10
) (
    input  logic        CLKin,
    input  logic        clr_n,
    input  logic        slow_clk,
    input  logic        load,
    input  logic [7:0]  preset_mm,
    input  logic [7:0]  preset_ss,
    input  logic        start,
    input  logic        stop,
    output logic [15:0] digits,
    output logic        running,
    output logic        done,
    output logic        expired
`ifdef TIMER_WARN_EN
    ,
    output logic        warn
`endif
);

    state_t      state_r, state_next_s;
    logic        slow_q_r;
    logic        tick_s;
    logic        dec_s;
    logic [15:0] digits_r, digits_next_s;
    logic [15:0] dec_val_s;
    logic [4:0]  borrow_s;
    logic        running_r, done_r, expired_r;
    logic        running_next_s, done_next_s, expired_next_s;

    assign tick_s      = slow_clk & ~slow_q_r;
    assign dec_s       = (state_r == RUN) && tick_s && !load && !stop && !start;
    assign borrow_s[0] = dec_s;

    bcd_digit_dec u_s_units (.digit(digits_r[3:0]),   .borrow_in(borrow_s[0]), .wrap_val(BCD_MAX),
                             .result(dec_val_s[3:0]),   .borrow_out(borrow_s[1]));
    bcd_digit_dec u_s_tens  (.digit(digits_r[7:4]),   .borrow_in(borrow_s[1]), .wrap_val(SEC_TENS_MAX),
                             .result(dec_val_s[7:4]),   .borrow_out(borrow_s[2]));
    bcd_digit_dec u_m_units (.digit(digits_r[11:8]),  .borrow_in(borrow_s[2]), .wrap_val(BCD_MAX),
                             .result(dec_val_s[11:8]),  .borrow_out(borrow_s[3]));
    bcd_digit_dec u_m_tens  (.digit(digits_r[15:12]), .borrow_in(borrow_s[3]), .wrap_val(BCD_MAX),
                             .result(dec_val_s[15:12]), .borrow_out(borrow_s[4]));

    // Counter next value: clamped preset on load, otherwise decrement (never below 00:00)
    always_comb begin
        digits_next_s = digits_r;
        if (load) begin
            digits_next_s = {clamp_digit(preset_mm[7:4], BCD_MAX),
                             clamp_digit(preset_mm[3:0], BCD_MAX),
                             clamp_digit(preset_ss[7:4], SEC_TENS_MAX),
                             clamp_digit(preset_ss[3:0], BCD_MAX)};
        end else if (dec_s && !borrow_s[4]) begin
            digits_next_s = dec_val_s;
        end else begin
            digits_next_s = digits_r;
        end
    end

    // Next-state logic; command priority load > stop > start > tick
    always_comb begin
        state_next_s = state_r;
        if (load) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE, PAUSE: begin
                    if (stop)
                        state_next_s = state_r;
                    else if (start)
                        state_next_s = (digits_r == 16'h0000) ? DONE : RUN;
                    else
                        state_next_s = state_r;
                end
                RUN: begin
                    if (stop)
                        state_next_s = PAUSE;
                    else if (!start && tick_s && (digits_r == 16'h0001))
                        state_next_s = DONE;
                    else
                        state_next_s = RUN;
                end
                DONE:    state_next_s = DONE;
                default: state_next_s = IDLE;
            endcase
        end
    end

    // Output decode from the upcoming state so the registered flags track state_r
    always_comb begin
        running_next_s = (state_next_s == RUN);
        done_next_s    = (state_next_s == DONE);
        expired_next_s = (state_next_s == DONE) && (state_r != DONE);
    end

    // State, counter, slow_clk sampler and output registers
    always_ff @(posedge CLKin) begin
        if (!clr_n) begin
            state_r   <= IDLE;
            slow_q_r  <= 1'b1;
            digits_r  <= 16'h0000;
            running_r <= 1'b0;
            done_r    <= 1'b0;
            expired_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            slow_q_r  <= slow_clk;
            digits_r  <= digits_next_s;
            running_r <= running_next_s;
            done_r    <= done_next_s;
            expired_r <= expired_next_s;
        end
    end

    assign digits  = digits_r;
    assign running = running_r;
    assign done    = done_r;
    assign expired = expired_r;

`ifdef TIMER_WARN_EN
    logic        warn_r, warn_next_s;
    logic [12:0] secs_next_s;

    assign secs_next_s = total_secs(digits_next_s);

    // Warning level: running or paused with 1..WARN_SECS seconds left
    always_comb begin
        warn_next_s = 1'b0;
        if ((state_next_s == RUN) || (state_next_s == PAUSE))
            warn_next_s = (secs_next_s != 13'd0) && (secs_next_s <= 13'(WARN_SECS));
        else
            warn_next_s = 1'b0;
    end

    // Warning register
    always_ff @(posedge CLKin) begin
        if (!clr_n)
            warn_r <= 1'b0;
        else
            warn_r <= warn_next_s;
    end

    assign warn = warn_r;
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// Table-driven bench for countdown_timer; warn checks are included when TIMER_WARN_EN is defined.
module tb_countdown_timer;

    logic        CLKin = 1'b0;
    logic        clr_n, slow_clk, load, start, stop;
    logic [7:0]  preset_mm, preset_ss;
    logic [15:0] digits;
    logic        running, done, expired;
`ifdef TIMER_WARN_EN
    logic        warn;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 CLKin = ~CLKin;

    countdown_timer #(.WARN_SECS(10)) dut (
        .CLKin(CLKin), .clr_n(clr_n), .slow_clk(slow_clk), .load(load),
        .preset_mm(preset_mm), .preset_ss(preset_ss), .start(start), .stop(stop),
        .digits(digits), .running(running), .done(done), .expired(expired)
`ifdef TIMER_WARN_EN
        , .warn(warn)
`endif
    );

    typedef struct {
        string       name;
        logic        rn;
        logic        ld;
        logic [7:0]  mm;
        logic [7:0]  ss;
        logic        st;
        logic        sp;
        logic        sc;
        logic [15:0] dg;
        logic        run;
        logic        dn;
        logic        ex;
        logic        wc;
        logic        wn;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string n, input logic rn, input logic ld, input logic [7:0] mm,
                       input logic [7:0] ss, input logic st, input logic sp, input logic sc,
                       input logic [15:0] dg, input logic run, input logic dn, input logic ex,
                       input logic wc = 1'b0, input logic wn = 1'b0);
        vec_t v;
        v.name = n; v.rn = rn; v.ld = ld; v.mm = mm; v.ss = ss; v.st = st; v.sp = sp; v.sc = sc;
        v.dg = dg; v.run = run; v.dn = dn; v.ex = ex; v.wc = wc; v.wn = wn;
        vecs.push_back(v);
    endtask

    task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    initial begin
        clr_n = 1'b0; slow_clk = 1'b1; load = 1'b0; start = 1'b0; stop = 1'b0;
        preset_mm = 8'h00; preset_ss = 8'h00;

        //   name         rn ld  mm     ss     st sp sc  digits    run dn ex
        add("rst0",       0, 0, 8'h00, 8'h00, 0, 0, 1, 16'h0000, 0, 0, 0);
        add("rst1",       0, 0, 8'h00, 8'h00, 0, 0, 1, 16'h0000, 0, 0, 0);
        add("A_ld0100",   1, 1, 8'h01, 8'h00, 0, 0, 1, 16'h0100, 0, 0, 0);
        add("A_start",    1, 0, 8'h00, 8'h00, 1, 0, 0, 16'h0100, 1, 0, 0);
        add("A_tick",     1, 0, 8'h00, 8'h00, 0, 0, 1, 16'h0059, 1, 0, 0);
        add("A_lo",       1, 0, 8'h00, 8'h00, 0, 0, 0, 16'h0059, 1, 0, 0);
        add("B_ld1000",   1, 1, 8'h10, 8'h00, 0, 0, 0, 16'h1000, 0, 0, 0);
        add("B_start",    1, 0, 8'h00, 8'h00, 1, 0, 0, 16'h1000, 1, 0, 0);
        add("B_tick",     1, 0, 8'h00, 8'h00, 0, 0, 1, 16'h0959, 1, 0, 0);
        add("B_lo",       1, 0, 8'h00, 8'h00, 0, 0, 0, 16'h0959, 1, 0, 0);
        add("C_ld0002",   1, 1, 8'h00, 8'h02, 0, 0, 0, 16'h0002, 0, 0, 0);
        add("C_start",    1, 0, 8'h00, 8'h00, 1, 0, 0, 16'h0002, 1, 0, 0);
        add("C_tick1",    1, 0, 8'h00, 8'h00, 0, 0, 1, 16'h0001, 1, 0, 0);
        add("C_lo1",      1, 0, 8'h00, 8'h00, 0, 0, 0, 16'h0001, 1, 0, 0);
        add("C_tick2",    1, 0, 8'h00, 8'h00, 0, 0, 1, 16'h0000, 0, 1, 1);
        add("C_expoff",   1, 0, 8'h00, 8'h00, 0, 0, 0, 16'h0000, 0, 1, 0);
        add("C_tickdone", 1, 0, 8'h00, 8'h00, 0, 0, 1, 16'h0000, 0, 1, 0);
        add("C_lo2",      1, 0, 8'h00, 8'h00, 0, 0, 0, 16'h0000, 0, 1, 0);
        add("C_startdn",  1, 0, 8'h00, 8'h00, 1, 0, 0, 16'h0000, 0, 1, 0);
        add("C_stopdn",   1, 0, 8'h00, 8'h00, 0, 1, 0, 16'h0000, 0, 1, 0);
        add("D_ld0030",   1, 1, 8'h00, 8'h30, 0, 0, 0, 16'h0030, 0, 0, 0);
        add("D_start",    1, 0, 8'h00, 8'h00, 1, 0, 0, 16'h0030, 1, 0, 0);
        add("D_t1",       1, 0, 8'h00, 8'h00, 0, 0, 1, 16'h0029, 1, 0, 0);
        add("D_l1",       1, 0, 8'h00, 8'h00, 0, 0, 0, 16'h0029, 1, 0, 0);
        add("D_t2",       1, 0, 8'h00, 8'h00, 0, 0, 1, 16'h0028, 1, 0, 0);
        add("D_l2",       1, 0, 8'h00, 8'h00, 0, 0, 0, 16'h0028, 1, 0, 0);
        add("D_t3",       1, 0, 8'h00, 8'h00, 0, 0, 1, 16'h0027, 1, 0, 0);
        add("D_l3",       1, 0, 8'h00, 8'h00, 0, 0, 0, 16'h0027, 1, 0, 0);
        add("D_stoptick", 1, 0, 8'h00, 8'h00, 0, 1, 1, 16'h0027, 0, 0, 0);
        add("D_pl",       1, 0, 8'h00, 8'h00, 0, 0, 0, 16'h0027, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            add("D_ptick",  1, 0, 8'h00, 8'h00, 0, 0, 1, 16'h0027, 0, 0, 0);
            add("D_plo",    1, 0, 8'h00, 8'h00, 0, 0, 0, 16'h0027, 0, 0, 0);
        end
        add("D_resume",   1, 0, 8'h00, 8'h00, 1, 0, 0, 16'h0027, 1, 0, 0);
        add("D_t4",       1, 0, 8'h00, 8'h00, 0, 0, 1, 16'h0026, 1, 0, 0);
        add("D_l4",       1, 0, 8'h00, 8'h00, 0, 0, 0, 16'h0026, 1, 0, 0);
        add("D_stop2",    1, 0, 8'h00, 8'h00, 0, 1, 0, 16'h0026, 0, 0, 0);
        add("D_starttk",  1, 0, 8'h00, 8'h00, 1, 0, 1, 16'h0026, 1, 0, 0);
        add("D_l5",       1, 0, 8'h00, 8'h00, 0, 0, 0, 16'h0026, 1, 0, 0);
        add("D_t5",       1, 0, 8'h00, 8'h00, 0, 0, 1, 16'h0025, 1, 0, 0);
        add("D_l6",       1, 0, 8'h00, 8'h00, 0, 0, 0, 16'h0025, 1, 0, 0);
        add("E_stopstrt", 1, 0, 8'h00, 8'h00, 1, 1, 0, 16'h0025, 0, 0, 0);
        add("E_resume",   1, 0, 8'h00, 8'h00, 1, 0, 0, 16'h0025, 1, 0, 0);
        add("E_ldclamp",  1, 1, 8'hA7, 8'h9F, 1, 0, 0, 16'h9759, 0, 0, 0);
        add("E_lo",       1, 0, 8'h00, 8'h00, 0, 0, 0, 16'h9759, 0, 0, 0);
        add("E_idletick", 1, 0, 8'h00, 8'h00, 0, 0, 1, 16'h9759, 0, 0, 0);
        add("E_lo2",      1, 0, 8'h00, 8'h00, 0, 0, 0, 16'h9759, 0, 0, 0);
        add("E_start",    1, 0, 8'h00, 8'h00, 1, 0, 0, 16'h9759, 1, 0, 0);
        add("E_ldtick",   1, 1, 8'h00, 8'h05, 0, 0, 1, 16'h0005, 0, 0, 0);
        add("E_lo3",      1, 0, 8'h00, 8'h00, 0, 0, 0, 16'h0005, 0, 0, 0);
        add("F_ld0000",   1, 1, 8'h00, 8'h00, 0, 0, 0, 16'h0000, 0, 0, 0);
        add("F_startzero",1, 0, 8'h00, 8'h00, 1, 0, 0, 16'h0000, 0, 1, 1);
        add("F_lo",       1, 0, 8'h00, 8'h00, 0, 0, 0, 16'h0000, 0, 1, 0);
        add("G_ld0003",   1, 1, 8'h00, 8'h03, 0, 0, 0, 16'h0003, 0, 0, 0);
        add("G_start",    1, 0, 8'h00, 8'h00, 1, 0, 0, 16'h0003, 1, 0, 0);
        add("G_tick",     1, 0, 8'h00, 8'h00, 0, 0, 1, 16'h0002, 1, 0, 0);
        add("G_rstrun",   0, 0, 8'h00, 8'h00, 0, 0, 1, 16'h0000, 0, 0, 0);
        add("G_rsthold",  0, 0, 8'h00, 8'h00, 0, 0, 1, 16'h0000, 0, 0, 0);
        add("G_ld0004",   1, 1, 8'h00, 8'h04, 0, 0, 1, 16'h0004, 0, 0, 0);
        add("G_starthi",  1, 0, 8'h00, 8'h00, 1, 0, 1, 16'h0004, 1, 0, 0);
        add("G_holdhi",   1, 0, 8'h00, 8'h00, 0, 0, 1, 16'h0004, 1, 0, 0);
        add("G_lo",       1, 0, 8'h00, 8'h00, 0, 0, 0, 16'h0004, 1, 0, 0);
        add("G_tick2",    1, 0, 8'h00, 8'h00, 0, 0, 1, 16'h0003, 1, 0, 0);
`ifdef TIMER_WARN_EN
        add("W_ld0012",   1, 1, 8'h00, 8'h12, 0, 0, 0, 16'h0012, 0, 0, 0, 1, 0);
        add("W_start",    1, 0, 8'h00, 8'h00, 1, 0, 0, 16'h0012, 1, 0, 0, 1, 0);
        add("W_t11",      1, 0, 8'h00, 8'h00, 0, 0, 1, 16'h0011, 1, 0, 0, 1, 0);
        add("W_l11",      1, 0, 8'h00, 8'h00, 0, 0, 0, 16'h0011, 1, 0, 0, 1, 0);
        add("W_t10",      1, 0, 8'h00, 8'h00, 0, 0, 1, 16'h0010, 1, 0, 0, 1, 1);
        add("W_l10",      1, 0, 8'h00, 8'h00, 0, 0, 0, 16'h0010, 1, 0, 0, 1, 1);
        add("W_pause",    1, 0, 8'h00, 8'h00, 0, 1, 0, 16'h0010, 0, 0, 0, 1, 1);
        add("W_ld0001",   1, 1, 8'h00, 8'h01, 0, 0, 0, 16'h0001, 0, 0, 0, 1, 0);
        add("W_start1",   1, 0, 8'h00, 8'h00, 1, 0, 0, 16'h0001, 1, 0, 0, 1, 1);
        add("W_done",     1, 0, 8'h00, 8'h00, 0, 0, 1, 16'h0000, 0, 1, 1, 1, 0);
`endif

        foreach (vecs[i]) begin
            clr_n     = vecs[i].rn;
            load      = vecs[i].ld;
            preset_mm = vecs[i].mm;
            preset_ss = vecs[i].ss;
            start     = vecs[i].st;
            stop      = vecs[i].sp;
            slow_clk  = vecs[i].sc;
            @(posedge CLKin);
            #2;
            chk({vecs[i].name, ".digits"},  digits,          vecs[i].dg);
            chk({vecs[i].name, ".running"}, 16'(running),    16'(vecs[i].run));
            chk({vecs[i].name, ".done"},    16'(done),       16'(vecs[i].dn));
            chk({vecs[i].name, ".expired"}, 16'(expired),    16'(vecs[i].ex));
`ifdef TIMER_WARN_EN
            if (vecs[i].wc)
                chk({vecs[i].name, ".warn"}, 16'(warn), 16'(vecs[i].wn));
            else if (!vecs[i].rn)
                chk({vecs[i].name, ".warn_rst"}, 16'(warn), 16'h0000);
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
